pyjamask96_arb_ctrl: RTL and testbench
======================================

PYJAMASK96_ARB_CTRL -- requirements
Module: pyjamask96_arb_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 200, meaning the max cycles from core_start to the last output byte; used only under REQ-032.
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req_valid[i], i=0,1  input  1  requester i has a block pending.
REQ-005 SHALL have ports req_ready[i]  output  1  block accepted when req_valid[i]&req_ready[i].
REQ-006 SHALL have ports req_pt[i]  input  96  plaintext; req_key[i]  input  128  key.
REQ-007 SHALL have port rsp_valid  output  1  response held until accepted.
REQ-008 SHALL have port rsp_ready  input  1  consumer accepts the response.
REQ-009 SHALL have ports rsp_data  output  96  ciphertext; rsp_id  output  1  owning requester; rsp_err  output  1  aborted block.
REQ-010 SHALL have ports core_load  output  1, core_start  output  1, core_byte_in  output  8, core_key_in  output  8; these drive the Pyjamask-96 core.
REQ-011 SHALL have ports core_valid  input  1, core_byte_out  input  8; these come from the core.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement the states IDLE, LOAD, START, WAIT, COLLECT and RESP.
REQ-014 IDLE: if any req_valid, SHALL grant round-robin and pulse req_ready for the granted requester only, for one cycle.
REQ-015 On accept SHALL latch pt, key and id, then go to LOAD next cycle.
REQ-016 Round-robin: if both requesters are valid, SHALL grant the one not granted last; after reset, requester 0 has priority.
REQ-017 LOAD lasts exactly 16 cycles (beat 0..15); core_load=1 on beat 0 only.
REQ-018 core_key_in SHALL carry key byte n on beat n, MSB first (bits 127:120 on beat 0).
REQ-019 core_byte_in SHALL carry pt byte n on beats 0..11, MSB first, and 0 on beats 12..15.
REQ-020 START: core_start=1 for exactly one cycle, then go to WAIT.
REQ-021 WAIT: on the first cycle with core_valid=1, SHALL capture byte 0 and enter COLLECT.
REQ-022 COLLECT: SHALL capture a byte only on cycles with core_valid=1; byte k goes to rsp_data bits [95-8k:88-8k].
REQ-023 A core_valid gap during COLLECT SHALL stall the byte counter, not reset it.
REQ-024 After byte 11, SHALL enter RESP with rsp_valid=1 and rsp_err=0.
REQ-025 RESP: rsp_valid, rsp_data, rsp_id and rsp_err SHALL stay stable until rsp_ready=1, then go to IDLE next cycle.
REQ-026 No req_ready outside IDLE; requests arriving while busy SHALL wait, not be dropped.
REQ-027 Total latency from accept to rsp_valid SHALL be 1+16+1+W+12 cycles, where W = WAIT cycles, assuming no valid gaps.
REQ-028 Outside LOAD and START, core_load, core_start, core_byte_in and core_key_in SHALL be 0.

Reset
REQ-029 On reset_n low, SHALL immediately force IDLE and set every output to 0, including mid-operation.
REQ-030 Reset SHALL clear the byte/beat counters and latched operands, and point round-robin to requester 0.
REQ-031 After release, SHALL accept no request before the first rising edge with reset_n high.

Configuration
REQ-032 With macro PYJ_ARB_TIMEOUT_EN defined, SHALL count cycles from START; at count TIMEOUT before byte 11 is captured, SHALL enter RESP with rsp_err=1 and rsp_data=0.
REQ-033 With PYJ_ARB_TIMEOUT_EN undefined, rsp_err SHALL be constant 0, WAIT/COLLECT SHALL wait indefinitely, and no timeout counter is present.

Verification
REQ-034 Single request: req0 with pt=96'h0, key=128'h0 -> 16 LOAD beats, one core_start, rsp_data equals the model output, rsp_id=0.
REQ-035 Both requesters valid in the same cycle after reset -> req0 served first, then req1; alternation holds over 4 blocks.
REQ-036 Core drops core_valid for 3 cycles after byte 5 -> 12 bytes still assembled correctly; latency +3.
REQ-037 rsp_ready held low 10 cycles -> rsp fields stable, no req_ready, busy=1 throughout.
REQ-038 reset_n asserted on LOAD beat 7 -> all outputs 0 asynchronously; next request restarts at beat 0.
REQ-039 PYJ_ARB_TIMEOUT_EN, TIMEOUT=20, core_valid never asserted -> rsp_valid with rsp_err=1, rsp_data=0, 20 cycles after START.

Source files
------------

// File: rtl/pyjamask96_arb_ctrl.sv
// Two-requester round-robin front end that feeds a byte-serial Pyjamask-96 core and returns its ciphertext.
// Define PYJ_ARB_TIMEOUT_EN to abort a block with rsp_err=1 when the core takes TIMEOUT cycles from START.
module pyjamask96_arb_ctrl #(
   parameter int TIMEOUT = 200
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [191:0] req_pt,
   input  logic [255:0] req_key,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [95:0]  rsp_data,
   output logic         rsp_id,
   output logic         rsp_err,
   output logic         core_load,
   output logic         core_start,
   output logic [7:0]   core_byte_in,
   output logic [7:0]   core_key_in,
   input  logic         core_valid,
   input  logic [7:0]   core_byte_out,
   output logic         busy
);

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, COLLECT, RESP} state_t;

   state_t       state, state_nxt;
   logic [3:0]   beat;
   logic [3:0]   byte_cnt;
   logic [95:0]  pt_q;
   logic [95:0]  data_q;
   logic [127:0] key_q;
   logic         id_q;
   logic         last_grant;
   logic         grant;
   logic         accept;
   logic         capture;
   logic         last_byte;
   logic         timeout;

   // With both requesters pending, the one not served last wins.
   assign grant     = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
   assign accept    = (state == IDLE) && (|req_valid);
   assign capture   = ((state == WAIT) || (state == COLLECT)) && core_valid;
   assign last_byte = capture && (byte_cnt == 4'd11);

`ifdef PYJ_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] tcnt;
   logic          err_q;

   // Zero during the START cycle, so reaching TIMEOUT-1 in WAIT/COLLECT lands RESP TIMEOUT cycles after START.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tcnt  <= '0;
         err_q <= 1'b0;
      end else begin
         if (accept)
            tcnt <= '0;
         else if ((state == START) || (state == WAIT) || (state == COLLECT))
            tcnt <= tcnt + TW'(1);
         if (accept)
            err_q <= 1'b0;
         else if (timeout)
            err_q <= 1'b1;
      end
   end

   assign timeout = ((state == WAIT) || (state == COLLECT)) && (tcnt == TW'(TIMEOUT - 1)) && !last_byte;
   assign rsp_err = rsp_valid & err_q;
`else
   logic unused_timeout;

   assign unused_timeout = ^TIMEOUT;
   assign timeout        = 1'b0;
   assign rsp_err        = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      req_ready    = 2'b00;
      core_load    = 1'b0;
      core_start   = 1'b0;
      core_byte_in = 8'h00;
      core_key_in  = 8'h00;
      case (state)
         IDLE: begin
            if (|req_valid) begin
               state_nxt = LOAD;
               req_ready = {grant, ~grant} & {2{reset_n}};
            end
         end
         LOAD: begin
            core_load   = (beat == 4'd0);
            core_key_in = key_q[{4'd15 - beat, 3'b000} +: 8];
            if (beat < 4'd12)
               core_byte_in = pt_q[{4'd11 - beat, 3'b000} +: 8];
            if (beat == 4'd15)
               state_nxt = START;
         end
         START: begin
            core_start = 1'b1;
            state_nxt  = WAIT;
         end
         WAIT: begin
            if (timeout)
               state_nxt = RESP;
            else if (capture)
               state_nxt = COLLECT;
         end
         COLLECT: begin
            if (last_byte || timeout)
               state_nxt = RESP;
         end
         RESP: begin
            if (rsp_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         beat       <= 4'd0;
         byte_cnt   <= 4'd0;
         pt_q       <= '0;
         key_q      <= '0;
         data_q     <= '0;
         id_q       <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         if (accept) begin
            pt_q       <= grant ? req_pt[191:96] : req_pt[95:0];
            key_q      <= grant ? req_key[255:128] : req_key[127:0];
            id_q       <= grant;
            last_grant <= grant;
            beat       <= 4'd0;
            byte_cnt   <= 4'd0;
            data_q     <= '0;
         end
         if (state == LOAD)
            beat <= beat + 4'd1;
         // Gaps in core_valid simply hold byte_cnt; byte k fills the k-th byte from the top.
         if (capture) begin
            data_q[{4'd11 - byte_cnt, 3'b000} +: 8] <= core_byte_out;
            byte_cnt                                <= byte_cnt + 4'd1;
         end
         if (timeout)
            data_q <= '0;
      end
   end

   assign rsp_valid = (state == RESP);
   assign rsp_data  = rsp_valid ? data_q : 96'h0;
   assign rsp_id    = rsp_valid & id_q;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_pyjamask96_arb_ctrl.sv
// Scoreboard bench for pyjamask96_arb_ctrl with a behavioural byte-serial core that
// returns out_k = pt_k ^ key_k ^ key_(15-k) ^ (8'h3C + k) for the bytes it was loaded with.
module tb_pyjamask96_arb_ctrl;

   typedef struct packed {
      logic        id;
      logic        err;
      logic [95:0] data;
   } rsp_t;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         v0, v1;
   logic [95:0]  pt0, pt1;
   logic [127:0] key0, key1;
   logic [1:0]   req_ready;
   logic         rsp_valid, rsp_ready;
   logic [95:0]  rsp_data;
   logic         rsp_id, rsp_err;
   logic         core_load, core_start;
   logic [7:0]   core_byte_in, core_key_in;
   logic         core_valid;
   logic [7:0]   core_byte_out;
   logic         busy;

   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   rsp_t sbq[$];

   int           lb = 99;
   int           load_pulses = 0, start_pulses = 0, load_cyc = 0, start_cyc = 0;
   logic [95:0]  cap_pt = '0;
   logic [127:0] cap_key = '0;
   int           wait_cyc = 2, gap_cyc = 0;
   bit           silent = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pyjamask96_arb_ctrl #(.TIMEOUT(20)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid({v1, v0}), .req_ready(req_ready),
      .req_pt({pt1, pt0}), .req_key({key1, key0}),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
      .core_load(core_load), .core_start(core_start),
      .core_byte_in(core_byte_in), .core_key_in(core_key_in),
      .core_valid(core_valid), .core_byte_out(core_byte_out),
      .busy(busy)
   );

   function automatic logic [95:0] model(input logic [95:0] pt, input logic [127:0] key);
      logic [95:0] r;
      for (int k = 0; k < 12; k++)
         r[95-8*k -: 8] = pt[95-8*k -: 8] ^ key[127-8*k -: 8] ^ key[127-8*(15-k) -: 8] ^ (8'h3C + 8'(k));
      return r;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic id, input logic err, input logic [95:0] data);
      rsp_t e;
      e.id = id; e.err = err; e.data = data;
      sbq.push_back(e);
   endtask

   // Response monitor: pops the scoreboard on every accepted response.
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (reset_n && rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL rsp_unexpected: got id=%0d data=%h, no response expected", rsp_id, rsp_data);
            end else begin
               e = sbq.pop_front();
               check("rsp_id", 128'(rsp_id), 128'(e.id));
               check("rsp_err", 128'(rsp_err), 128'(e.err));
               check("rsp_data", 128'(rsp_data), 128'(e.data));
            end
         end
      end
   end

   // Core-side load monitor: reassembles loaded operands and checks idle core inputs.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            lb = 99;
         end else begin
            if (core_load) begin
               lb = 0;
               load_pulses++;
               load_cyc = cyc;
            end
            if (core_start) begin
               start_pulses++;
               start_cyc = cyc;
            end
            if (lb < 16) begin
               cap_key[127-8*lb -: 8] = core_key_in;
               if (lb < 12)
                  cap_pt[95-8*lb -: 8] = core_byte_in;
               else
                  check("byte_in_pad", 128'(core_byte_in), 128'(0));
               lb++;
            end else begin
               check("core_idle", {core_load, core_byte_in, core_key_in}, 128'(0));
            end
         end
      end
   end

   // Behavioural core: wait_cyc negedges after START, stream 12 bytes, optional gap after byte 5.
   initial begin
      logic [95:0] o;
      core_valid = 1'b0;
      core_byte_out = 8'h00;
      forever begin
         @(negedge clk);
         if (reset_n && core_start && !silent) begin
            o = model(cap_pt, cap_key);
            repeat (wait_cyc) @(negedge clk);
            for (int k = 0; k < 12; k++) begin
               core_valid = 1'b1;
               core_byte_out = o[95-8*k -: 8];
               @(negedge clk);
               if (k == 5 && gap_cyc > 0) begin
                  core_valid = 1'b0;
                  core_byte_out = 8'hEE;
                  repeat (gap_cyc) @(negedge clk);
               end
            end
            core_valid = 1'b0;
            core_byte_out = 8'h00;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic accept_wait(input int id, output int acc);
      acc = -1;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (req_ready[id]) begin
            acc = cyc;
            break;
         end
      end
      if (acc < 0) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_wait: requester %0d got no req_ready, got 0 required 1", id);
      end else begin
         @(posedge clk);
         #1;
         if (id == 0) v0 = 1'b0; else v1 = 1'b0;
      end
   endtask

   task automatic send(input int id, input logic [95:0] pt, input logic [127:0] key, output int acc);
      @(posedge clk);
      #1;
      if (id == 0) begin pt0 = pt; key0 = key; v0 = 1'b1; end
      else         begin pt1 = pt; key1 = key; v1 = 1'b1; end
      accept_wait(id, acc);
   endtask

   task automatic wait_rsp(output int c);
      c = -1;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (rsp_valid) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) begin
         vectors++;
         miscompares++;
         $display("FAIL rsp_wait: rsp_valid got 0 required 1 within 500 cycles");
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         if (sbq.size() == 0) break;
      end
      check("drain_empty", 128'(sbq.size()), 128'(0));
      @(negedge clk);
      @(negedge clk);
      check("idle_busy", {busy, req_ready, rsp_valid}, 128'(0));
   endtask

   int acc, acc_a, acc_b, acc_c, acc_d, r, lp0, sp0;
   logic [95:0]  pt_x, pt_y;
   logic [127:0] key_x, key_y;
   logic [97:0]  snap;

   initial begin
      reset_n = 1'b0;
      v0 = 1'b0; v1 = 1'b0;
      pt0 = '0; pt1 = '0; key0 = '0; key1 = '0;
      rsp_ready = 1'b1;
      #2;
      check("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_err, core_load, core_start,
                              core_byte_in, core_key_in, busy}, 128'(0));
      check("reset_rsp_data", 128'(rsp_data), 128'(0));
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // Both requesters pending together right after reset: 0,1,0,1.
      wait_cyc = 1;
      push_exp(1'b0, 1'b0, model(96'h0123456789ABCDEF01234567, 128'h00112233445566778899AABBCCDDEEFF));
      push_exp(1'b1, 1'b0, model(96'hFFEEDDCCBBAA998877665544, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0));
      push_exp(1'b0, 1'b0, model(96'hA5A5A5A55A5A5A5AC3C3C3C3, 128'h13579BDF2468ACE0FEDCBA9876543210));
      push_exp(1'b1, 1'b0, model(96'h800000000000000000000001, 128'h80000000000000000000000000000001));
      fork
         begin
            send(0, 96'h0123456789ABCDEF01234567, 128'h00112233445566778899AABBCCDDEEFF, acc_a);
            send(0, 96'hA5A5A5A55A5A5A5AC3C3C3C3, 128'h13579BDF2468ACE0FEDCBA9876543210, acc_c);
         end
         begin
            send(1, 96'hFFEEDDCCBBAA998877665544, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, acc_b);
            send(1, 96'h800000000000000000000001, 128'h80000000000000000000000000000001, acc_d);
         end
      join
      check("rr_order_ab", 128'(acc_a < acc_b), 128'(1));
      check("rr_order_bc", 128'(acc_b < acc_c), 128'(1));
      check("rr_order_cd", 128'(acc_c < acc_d), 128'(1));
      drain();

      // Single all-zero block from requester 0 with two idle WAIT cycles.
      wait_cyc = 3;
      lp0 = load_pulses;
      sp0 = start_pulses;
      push_exp(1'b0, 1'b0, 96'h3C3D3E3F4041424344454647);
      send(0, 96'h0, 128'h0, acc);
      wait_rsp(r);
      check("latency_w2", 128'(r - acc), 128'(32));
      check("load_beat0_cycle", 128'(load_cyc - acc), 128'(1));
      check("start_cycle", 128'(start_cyc - acc), 128'(17));
      check("load_pulses", 128'(load_pulses - lp0), 128'(1));
      check("start_pulses", 128'(start_pulses - sp0), 128'(1));
      drain();

      // core_valid gap of 3 cycles after byte 5.
      wait_cyc = 2;
      gap_cyc = 3;
      pt_x = 96'hDEADBEEFCAFEF00D12345678;
      key_x = 128'h0102030405060708090A0B0C0D0E0F10;
      push_exp(1'b0, 1'b0, model(pt_x, key_x));
      send(0, pt_x, key_x, acc);
      wait_rsp(r);
      check("latency_gap3", 128'(r - acc), 128'(34));
      drain();
      gap_cyc = 0;

      // Response held 10 cycles while requester 0 waits.
      pt_x = 96'h111122223333444455556666;
      key_x = 128'hFEDCBA98765432100123456789ABCDEF;
      pt_y = 96'h77778888999900001111AAAA;
      key_y = 128'hC0FFEE00C0FFEE00C0FFEE00C0FFEE00;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      push_exp(1'b1, 1'b0, model(pt_x, key_x));
      push_exp(1'b0, 1'b0, model(pt_y, key_y));
      send(1, pt_x, key_x, acc);
      @(posedge clk);
      #1;
      pt0 = pt_y; key0 = key_y; v0 = 1'b1;
      wait_rsp(r);
      snap = {rsp_id, rsp_err, rsp_data};
      check("hold_first_value", 128'(snap), 128'({1'b1, 1'b0, model(pt_x, key_x)}));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, {1'b1, snap});
         check("hold_busy_ready", 128'({busy, req_ready}), 128'(3'b100));
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      send(0, pt_y, key_y, acc);
      drain();

      // Reset during LOAD beat 7, with a new request already pending.
      pt_x = 96'h0A0B0C0D0E0F101112131415;
      key_x = 128'h2122232425262728292A2B2C2D2E2F30;
      pt_y = 96'h5566778899AABBCCDDEEFF00;
      key_y = 128'h3132333435363738393A3B3C3D3E3F40;
      send(0, pt_x, key_x, acc);
      repeat (7) @(posedge clk);
      #2;
      check("key_beat7", 128'(core_key_in), 128'(key_x[71:64]));
      pt0 = pt_y; key0 = key_y; v0 = 1'b1;
      reset_n = 1'b0;
      #1;
      check("async_reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_err, core_load, core_start,
                                    core_byte_in, core_key_in, busy}, 128'(0));
      check("async_reset_rsp_data", 128'(rsp_data), 128'(0));
      @(posedge clk);
      @(negedge clk);
      check("reset_hold_ready", 128'({req_ready, busy}), 128'(0));
      @(posedge clk);
      #1 reset_n = 1'b1;
      push_exp(1'b0, 1'b0, model(pt_y, key_y));
      accept_wait(0, acc);
      repeat (2) @(negedge clk);
      check("restart_beat0", 128'(load_cyc - acc), 128'(1));
      drain();

`ifdef PYJ_ARB_TIMEOUT_EN
      // Core never answers: abort with rsp_err 20 cycles after START.
      silent = 1;
      push_exp(1'b0, 1'b1, 96'h0);
      send(0, 96'h123, 128'h456, acc);
      wait_rsp(r);
      check("timeout_cycles", 128'(r - start_cyc), 128'(20));
      drain();
      silent = 0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
